calc_seq: RTL

Command sequencer for the four-function decimal calculator. It accepts keypad commands through a valid/ready handshake and holds operand A, operand B and the pending operator. It runs add, sub or iterative shift-add multiply on its own datapath, with overflow and negative-result checks. It drives the value and status words that the display controller and the status LEDs consume.

---
 rtl/calc_seq.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/calc_seq.sv
// calc_seq: keypad command sequencer and add/sub/shift-add-multiply datapath for a decimal calculator
module calc_seq #(
  parameter int     WIDTH      = 27,
  parameter int     MAX_DIGITS = 8,
  parameter longint MAX_VALUE  = 99999999
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       cmd,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic [1:0]       status,
  output logic [WIDTH-1:0] value,
  output logic [3:0]       digit_cnt
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] OP_ADD = 2'b10, OP_SUB = 2'b11, OP_MUL = 2'b00;
  typedef enum logic [2:0] {S_A, S_OP, S_B, S_EXEC, S_SHOW, S_ERR} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a, a_n, b, b_n, mplr, mplr_n, oprnd, app_x, d_ext;
  logic [PW-1:0] prod, prod_n, mcand, mcand_n, step, res;
  logic [1:0] op, op_n, next_op, next_op_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] dcnt_n, app_c;
  logic chain, chain_n, take, is_dig, is_op, is_eq, done, err;
  assign cmd_ready = state != S_EXEC;
  assign status = state == S_EXEC ? 2'b01 : state == S_ERR ? 2'b10 : state == S_SHOW ? 2'b11 : 2'b00;
  assign value = state == S_ERR ? '0 : (state == S_B || state == S_EXEC) ? b : a;
  assign take = cmd_valid && cmd_ready;
  assign is_dig = cmd <= 4'd9;
  assign is_op = cmd inside {4'hA, 4'hB, 4'hC};
  assign is_eq = cmd == 4'hE;
  assign d_ext = WIDTH'(cmd);
  assign oprnd = state == S_B ? b : a;
  // digits beyond MAX_DIGITS are swallowed; leading zeros leave the count at 0
  assign app_x = digit_cnt < 4'(MAX_DIGITS) ? (oprnd << 3) + (oprnd << 1) + d_ext : oprnd;
  assign app_c = digit_cnt >= 4'(MAX_DIGITS) ? digit_cnt : app_x != '0 ? digit_cnt + 4'd1 : 4'd0;
  assign step = prod + (mplr[0] ? mcand : '0);
  assign res = op == OP_ADD ? PW'(a) + PW'(b) : op == OP_SUB ? PW'(a) - PW'(b) : step;
  assign err = (op == OP_SUB && a < b) || res > PW'(MAX_VALUE);
  assign done = op != OP_MUL || cnt == CW'(WIDTH - 1);
  always_comb begin
    state_n = state;
    a_n = a;
    b_n = b;
    op_n = op;
    next_op_n = next_op;
    chain_n = chain;
    dcnt_n = digit_cnt;
    prod_n = prod;
    mcand_n = mcand;
    mplr_n = mplr;
    cnt_n = cnt;
    if (state == S_EXEC) begin
      prod_n = step;
      mcand_n = mcand << 1;
      mplr_n = mplr >> 1;
      cnt_n = cnt + CW'(1);
      if (done && err) state_n = S_ERR;
      else if (done) begin
        a_n = res[WIDTH-1:0];
        b_n = '0;
        dcnt_n = '0;
        state_n = chain ? S_OP : S_SHOW;
        op_n = chain ? next_op : op;
      end
    end else if (take) begin
      case (state)
        S_A: begin
          if (is_dig) begin
            a_n = app_x;
            dcnt_n = app_c;
          end else if (is_op) begin
            op_n = cmd[1:0];
            state_n = S_OP;
          end else if (is_eq) state_n = S_SHOW;
        end
        S_OP: begin
          if (is_dig) begin
            b_n = d_ext;
            dcnt_n = 4'(cmd != 4'd0);
            state_n = S_B;
          end else if (is_op) op_n = cmd[1:0];
        end
        S_B: begin
          if (is_dig) begin
            b_n = app_x;
            dcnt_n = app_c;
          end else if (is_op || is_eq) begin
            state_n = S_EXEC;
            chain_n = is_op;
            next_op_n = is_op ? cmd[1:0] : next_op;
            prod_n = '0;
            mcand_n = PW'(a);
            mplr_n = b;
            cnt_n = '0;
          end
        end
        S_SHOW: begin
          if (is_dig) begin
            a_n = d_ext;
            dcnt_n = 4'(cmd != 4'd0);
            state_n = S_A;
          end else if (is_op) begin
            op_n = cmd[1:0];
            state_n = S_OP;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (!reset || (cmd_valid && cmd == 4'hF)) begin
      state <= S_A;
      a <= '0;
      b <= '0;
      op <= OP_ADD;
      next_op <= OP_ADD;
      chain <= 1'b0;
      digit_cnt <= '0;
      prod <= '0;
      mcand <= '0;
      mplr <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      a <= a_n;
      b <= b_n;
      op <= op_n;
      next_op <= next_op_n;
      chain <= chain_n;
      digit_cnt <= dcnt_n;
      prod <= prod_n;
      mcand <= mcand_n;
      mplr <= mplr_n;
      cnt <= cnt_n;
    end
  end
endmodule
